uart_event_framer: RTL and testbench
====================================

// Module: uart_event_framer
// PURPOSE
//  Buffers game events (mole move, hit, score, game over) and frames each one as a short
//  ASCII message for the uart_tx transmitter (FPGA -> PC).
//  Sits between the whack-a-mole top-level event sources and uart_tx; drives uart_tx's
//  tx_start/tx_data and obeys its uart_tx_busy. Replaces the ad-hoc one-byte mole sender.
//  Bursts of events are never lost while the FIFO has room.
// PARAMETERS
//  DEPTH       8  event FIFO entries; power of 2, >= 2
//  DEPTH_LOG2  3  log2(DEPTH); sizes the pointers and fifo_count (width DEPTH_LOG2+1)
// PORTS
//  clock       in   1  system clock, 100 MHz
//  reset       in   1  synchronous, active-high reset
//  clear       in   1  sync flush: empties the FIFO, aborts the frame, clears overflow
//  evt_valid   in   1  push request; one event per cycle when high
//  evt_type    in   2  0=MOLE 1=HIT 2=SCORE 3=OVER
//  evt_arg     in   6  MOLE: index 0-4 in arg[2:0]; SCORE: 0-63; ignored for HIT/OVER
//  evt_ready   out  1  = !full; combinational from FIFO state
//  tx_start    out  1  one-cycle pulse to uart_tx
//  tx_data     out  8  byte for uart_tx; stable from tx_start until the next tx_start
//  tx_busy     in   1  uart_tx_busy from uart_tx
//  fifo_count  out  DEPTH_LOG2+1  number of queued events (0..DEPTH)
//  overflow    out  1  sticky; set when a push is dropped
// BEHAVIOUR
//  Reset/clear: FIFO empty, FSM=IDLE, tx_start=0, tx_data=8'h00, fifo_count=0, overflow=0,
//   evt_ready=1.
//  Frames (ASCII, every frame ends in 8'h0A):
//   MOLE  "M",d,LF  d = "0"+arg[2:0]; arg[2:0]>4 sends "X"
//   HIT   "H",LF
//   SCORE "S",tens,ones,LF  decimal, always two digits (7 -> "07", 63 -> "63")
//   OVER  "O",LF
//  FIFO push: accepted when evt_valid and (!full or a pop occurs in the same cycle).
//   A push while full with no pop is dropped and sets overflow. No bypass path.
//  FIFO pop: occurs in the cycle the FSM leaves IDLE. The event is latched into the frame
//   register, which includes the tens/ones digits computed from the 6-bit arg.
//  FSM:
//   IDLE  -> LOAD   when FIFO is non-empty; pop and latch the event
//   LOAD  : if !tx_busy, pulse tx_start with the current frame byte -> GUARD;
//           otherwise stay in LOAD
//   GUARD : 1 cycle; tx_busy is ignored here (covers the uart_tx busy-rise latency) -> WAIT
//   WAIT  : when tx_busy==0, go to LOAD if more bytes remain in the frame, else to IDLE
//  Byte index counter runs 0..len-1; len is 2, 3 or 4 depending on the type.
//  Latency: an event pushed at cycle N into an empty, idle block with tx_busy=0 gives
//   tx_start=1 at N+2 with tx_data = header byte.
//  Frames are never interleaved. Events are sent in push order.
//  clear mid-frame: tx_start is forced low that cycle and the FSM goes to IDLE. A byte
//   already handed to uart_tx still completes on the line, but no further bytes of that
//   frame are sent. A push in the same cycle as clear is discarded.
//  reset has priority over clear. clear has priority over push/pop.
//  tx_busy stuck high: FSM waits indefinitely in LOAD/WAIT. The FIFO keeps accepting
//   pushes until full.
// STRUCTURE
//  Shared package wam_uart_pkg holds:
//   - EVT_MOLE/EVT_HIT/EVT_SCORE/EVT_OVER codes
//   - ASCII constants: M H S O X LF and "0"
//   - FSM state encodings
//  Sub-module: sync_fifo (DEPTH, WIDTH=8, sync active-high reset, clear, full/empty/count).
//   Each entry holds {type, arg}.
//  The framer FSM and the binary->2-digit BCD (compare/subtract by 10) are local to this block.
// TESTING
//  1 push MOLE arg=3, tx_busy model rises 1 cycle after start and lasts 20 cycles
//    -> bytes 4D 33 0A, first tx_start at N+2.
//  2 SCORE arg=7, then arg=63 -> "S07\n" then "S63\n" (53 30 37 0A 53 36 33 0A).
//  3 push 10 events back-to-back with DEPTH=8 while tx_busy is held high
//    -> evt_ready drops at 8 queued, overflow=1. The first 8 (or 9, counting the one
//       already popped) frames are emitted in order once busy is released.
//  4 FIFO full with a pop and a push in the same cycle -> push accepted,
//    fifo_count stays at DEPTH, overflow stays 0.
//  5 clear asserted after the 2nd byte of a SCORE frame
//    -> no further tx_start, fifo_count=0, overflow=0. The next event is framed from its
//       header byte.
//  6 reset mid-WAIT -> tx_start=0, tx_data=00, FSM in IDLE next cycle.
//    MOLE arg=6 -> "MX\n".

Source files
------------

// File: rtl/wam_uart_pkg.sv
// Shared definitions for the whack-a-mole UART event path.
//   - event type codes carried on evt_type
//   - ASCII bytes used to build the outgoing frames
//   - framer FSM state encoding (also exported on the debug port)
package wam_uart_pkg;

    // Event type codes
    localparam logic [1:0] EVT_MOLE  = 2'd0;
    localparam logic [1:0] EVT_HIT   = 2'd1;
    localparam logic [1:0] EVT_SCORE = 2'd2;
    localparam logic [1:0] EVT_OVER  = 2'd3;

    // ASCII constants
    localparam logic [7:0] ASCII_M    = 8'h4D;
    localparam logic [7:0] ASCII_H    = 8'h48;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_O    = 8'h4F;
    localparam logic [7:0] ASCII_X    = 8'h58;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // One queued event is {type[1:0], arg[5:0]}
    localparam int EVT_WIDTH = 8;

    // Framer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } framer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   clear        synchronous flush (same effect as reset)
//   push         write request; accepted when not full, or when a pop happens too
//   pop          read request; ignored when empty
//   wdata        data written on an accepted push
//   rdata        head entry, valid whenever empty is low
//   full/empty   occupancy flags
//   count        number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; stale contents are never read because empty gates pops.
    always_ff @(posedge clock) begin
        if (do_push && !reset && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_event_framer.sv
// Buffers game events and frames each one as a short ASCII message for uart_tx.
//   MOLE  -> "M", digit (or "X" if index > 4), LF
//   HIT   -> "H", LF
//   SCORE -> "S", tens, ones, LF
//   OVER  -> "O", LF
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   clear          synchronous flush of FIFO, current frame and overflow flag
//   evt_valid      event push request (type/arg sampled when high)
//   evt_type/arg   event code and argument
//   evt_ready      high while the FIFO has room
//   tx_start       one-cycle start pulse to uart_tx
//   tx_data        byte for uart_tx, stable from tx_start to the next tx_start
//   tx_busy        uart_tx busy flag
//   fifo_count     queued events
//   overflow       sticky: an event was dropped on a full FIFO
//   fsm_state      debug view of the framer state
//
// Handshakes: evt_valid/evt_ready -- an event transfers on a cycle where evt_valid
// is high and the FIFO can take it (not full, or the head is popped that cycle);
// evt_valid with a full FIFO and no pop drops the event and sets overflow.
// tx_start/tx_busy -- a byte is handed over only on a cycle where tx_busy is low.
module uart_event_framer
    import wam_uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  evt_valid,
    input  logic [1:0]            evt_type,
    input  logic [5:0]            evt_arg,
    output logic                  evt_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output framer_state_t         fsm_state
);

    framer_state_t          state;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [EVT_WIDTH-1:0]   fifo_rdata;

    logic [7:0]             frame_bytes [4];
    logic [1:0]             frame_last;
    logic [1:0]             idx;

    logic [7:0]             next_bytes [4];
    logic [1:0]             next_last;
    logic [7:0]             next_bcd;

    // Binary 0..63 to two BCD digits by repeated compare/subtract of 10.
    function automatic logic [7:0] to_bcd(input logic [5:0] value);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = value;
        tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (EVT_WIDTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (evt_valid && !clear),
        .pop   (fifo_pop),
        .wdata ({evt_type, evt_arg}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign evt_ready = !fifo_full;
    assign fsm_state = state;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !clear;

    // Start is combinational so the header goes out two cycles after the push;
    // clear and reset suppress it in their own cycle.
    assign tx_start  = (state == ST_LOAD) && !tx_busy && !clear && !reset;

    // Frame built from the FIFO head; latched when the FSM leaves IDLE.
    assign next_bcd = to_bcd(fifo_rdata[5:0]);

    always_comb begin
        next_bytes[0] = ASCII_O;
        next_bytes[1] = ASCII_LF;
        next_bytes[2] = ASCII_LF;
        next_bytes[3] = ASCII_LF;
        next_last     = 2'd1;
        case (fifo_rdata[7:6])
            EVT_MOLE: begin
                next_bytes[0] = ASCII_M;
                next_bytes[1] = (fifo_rdata[2:0] > 3'd4) ? ASCII_X
                                                         : ASCII_ZERO + {5'd0, fifo_rdata[2:0]};
                next_bytes[2] = ASCII_LF;
                next_last     = 2'd2;
            end
            EVT_HIT: begin
                next_bytes[0] = ASCII_H;
                next_last     = 2'd1;
            end
            EVT_SCORE: begin
                next_bytes[0] = ASCII_S;
                next_bytes[1] = ASCII_ZERO + {4'd0, next_bcd[7:4]};
                next_bytes[2] = ASCII_ZERO + {4'd0, next_bcd[3:0]};
                next_bytes[3] = ASCII_LF;
                next_last     = 2'd3;
            end
            default: begin
                next_bytes[0] = ASCII_O;
                next_last     = 2'd1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state      <= ST_IDLE;
            tx_data    <= 8'h00;
            idx        <= 2'd0;
            frame_last <= 2'd0;
            for (int i = 0; i < 4; i++) frame_bytes[i] <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        frame_bytes <= next_bytes;
                        frame_last  <= next_last;
                        idx         <= 2'd0;
                        tx_data     <= next_bytes[0];
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!tx_busy) state <= ST_GUARD;
                end
                // uart_tx raises busy one cycle after start; skip that cycle.
                ST_GUARD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (idx == frame_last) begin
                            state <= ST_IDLE;
                        end else begin
                            idx     <= idx + 2'd1;
                            tx_data <= frame_bytes[idx + 2'd1];
                            state   <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            overflow <= 1'b0;
        end else if (evt_valid && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_event_framer.sv
// Bench for uart_event_framer: a uart_tx busy model, event driver tasks and a
// byte scoreboard fed at push time and drained on every tx_start.
module tb_uart_event_framer;
    import wam_uart_pkg::*;

    localparam int BUSY_LEN = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          evt_valid = 1'b0;
    logic [1:0]    evt_type = 2'd0;
    logic [5:0]    evt_arg = 6'd0;
    logic          evt_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic [3:0]    fifo_count;
    logic          overflow;
    framer_state_t fsm_state;

    logic          hold_busy = 1'b0;
    int            busy_cnt;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_starts = 0;
    logic [7:0]    exp_q[$];

    uart_event_framer #(.DEPTH(8), .DEPTH_LOG2(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .evt_valid  (evt_valid),
        .evt_type   (evt_type),
        .evt_arg    (evt_arg),
        .evt_ready  (evt_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .fsm_state  (fsm_state)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // uart_tx busy model: rises the cycle after start, lasts BUSY_LEN cycles.
    always @(posedge clock) begin
        if (reset)                busy_cnt <= 0;
        else if (tx_start)        busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || hold_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected frame bytes for one event
    function automatic void push_exp(input logic [1:0] t, input logic [5:0] a);
        int v;
        v = int'(a);
        case (t)
            EVT_MOLE: begin
                exp_q.push_back(8'h4D);
                exp_q.push_back((a[2:0] > 3'd4) ? 8'h58 : 8'(8'h30 + a[2:0]));
                exp_q.push_back(8'h0A);
            end
            EVT_HIT: begin
                exp_q.push_back(8'h48);
                exp_q.push_back(8'h0A);
            end
            EVT_SCORE: begin
                exp_q.push_back(8'h53);
                exp_q.push_back(8'(8'h30 + v / 10));
                exp_q.push_back(8'(8'h30 + v % 10));
                exp_q.push_back(8'h0A);
            end
            default: begin
                exp_q.push_back(8'h4F);
                exp_q.push_back(8'h0A);
            end
        endcase
    endfunction

    // Scoreboard: every start pops one expected byte.
    always @(negedge clock) begin
        if (!reset && tx_start) begin
            n_starts++;
            check("start_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic push_evt(input logic [1:0] t, input logic [5:0] a, input bit accept);
        @(negedge clock);
        evt_valid = 1'b1;
        evt_type  = t;
        evt_arg   = a;
        if (accept) push_exp(t, a);
        @(posedge clock);
        #1;
        evt_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_state(input framer_state_t s, input int budget, input string tag);
        int n;
        n = 0;
        while (fsm_state != s && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(fsm_state), 32'(s));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fsm_state != ST_IDLE) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [1:0] rt;
        logic [5:0] ra;
        int         base;
        int         n;

        // Reset
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ready", 32'(evt_ready), 32'd1);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));

        // 1: MOLE 3, header at N+2
        push_evt(EVT_MOLE, 6'd3, 1'b1);
        @(negedge clock);
        check("lat_n1_start", 32'(tx_start), 32'd0);
        @(negedge clock);
        check("lat_n2_start", 32'(tx_start), 32'd1);
        check("lat_n2_data", 32'(tx_data), 32'h4D);
        drain("t1_drain");

        // 2: SCORE 7 and 63 back-to-back, MOLE with high arg bits, MOLE 4
        push_evt(EVT_SCORE, 6'd7, 1'b1);
        push_evt(EVT_SCORE, 6'd63, 1'b1);
        push_evt(EVT_MOLE, 6'b101_010, 1'b1);
        push_evt(EVT_MOLE, 6'd4, 1'b1);
        drain("t2_drain");

        // Random event mix
        for (int i = 0; i < 8; i++) begin
            rt = 2'($urandom_range(0, 3));
            ra = 6'($urandom_range(0, 63));
            push_evt(rt, ra, 1'b1);
        end
        drain("rand_drain");

        // 3: burst of 10 with busy held; one popped, eight queued, last dropped
        @(negedge clock);
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rt = 2'($urandom_range(0, 3));
            ra = 6'($urandom_range(0, 63));
            push_evt(rt, ra, 1'b1);
        end
        check("burst_count8", 32'(fifo_count), 32'd8);
        check("burst_ready0", 32'(evt_ready), 32'd0);
        check("burst_ovf0", 32'(overflow), 32'd0);
        push_evt(EVT_HIT, 6'd0, 1'b0);
        check("burst_ovf1", 32'(overflow), 32'd1);
        check("burst_count_hold", 32'(fifo_count), 32'd8);
        @(negedge clock);
        hold_busy = 1'b0;
        drain("t3_drain");
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: full FIFO, push in the pop cycle
        pulse_clear();
        check("clr_ovf", 32'(overflow), 32'd0);
        @(negedge clock);
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) push_evt(EVT_SCORE, 6'(i * 7), 1'b1);
        check("t4_full", 32'(fifo_count), 32'd8);
        @(negedge clock);
        hold_busy = 1'b0;
        wait_state(ST_IDLE, 300, "t4_reach_idle");
        check("t4_pre_count", 32'(fifo_count), 32'd8);
        evt_valid = 1'b1;
        evt_type  = EVT_OVER;
        evt_arg   = 6'd0;
        push_exp(EVT_OVER, 6'd0);
        @(posedge clock);
        #1;
        evt_valid = 1'b0;
        check("t4_count", 32'(fifo_count), 32'd8);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_state", 32'(fsm_state), 32'(ST_LOAD));
        drain("t4_drain");

        // 5: clear after 2nd byte of SCORE; push in the clear cycle is discarded
        base = n_starts;
        push_evt(EVT_SCORE, 6'd42, 1'b1);
        n = 0;
        while (n_starts < base + 2 && n < 300) begin
            @(posedge clock);
            n++;
        end
        check("t5_two_bytes", 32'(n_starts - base), 32'd2);
        @(negedge clock);
        clear     = 1'b1;
        evt_valid = 1'b1;
        evt_type  = EVT_HIT;
        @(posedge clock);
        #1;
        clear     = 1'b0;
        evt_valid = 1'b0;
        exp_q.delete();
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        check("t5_state", 32'(fsm_state), 32'(ST_IDLE));
        check("t5_data", 32'(tx_data), 32'h00);
        repeat (60) @(negedge clock);
        check("t5_no_more", 32'(n_starts - base), 32'd2);
        push_evt(EVT_OVER, 6'd0, 1'b1);
        drain("t5_drain");

        // 6: reset mid-WAIT, then MOLE 6 -> "MX\n"
        push_evt(EVT_HIT, 6'd0, 1'b1);
        wait_state(ST_WAIT, 100, "t6_reach_wait");
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("t6_start", 32'(tx_start), 32'd0);
        check("t6_data", 32'(tx_data), 32'h00);
        check("t6_state", 32'(fsm_state), 32'(ST_IDLE));
        check("t6_count", 32'(fifo_count), 32'd0);
        push_evt(EVT_MOLE, 6'd6, 1'b1);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
